spi_master_driver: RTL

- SPI master (mode 0: CPOL=0, CPHA=0, MSB first). It is the initiator end for spi_slave_driver.
- Serialises a parallel word onto mosi and drives sclk/cs from the system clock. Deserialises miso into data_out.
- Used in on-chip loopback benches and as the host-side driver for external SPI slaves.
- One frame is exactly DATA_WIDTH sclk pulses, started by a single-cycle start request.

---
 rtl/spi_master_driver.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/spi_master_driver.sv
// spi_master_driver: SPI mode-0 master (CPOL=0, CPHA=0, MSB first).
// One frame is DATA_WIDTH sclk pulses; each sclk half-period lasts SCLK_HALF
// clk cycles. miso is sampled on the clk edge that drops sclk, and mosi only
// changes while sclk is low.
// Optional build macro SPI_MASTER_BURST_EN: a start seen on the last edge of
// a frame chains straight into the next frame with cs kept low.
module spi_master_driver #(
  parameter int DATA_WIDTH = 8,
  parameter int SCLK_HALF  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  ready,
  output logic                  busy,
  output logic                  mosi,
  input  logic                  miso,
  output logic                  sclk,
  output logic                  cs
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int HW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_HIGH,
    ST_LOW,
    ST_HOLD
  } state_t;

  state_t                  state_reg, state_next;
  logic [HW-1:0]           hcnt_reg, hcnt_next;
  logic [CW-1:0]           bit_cnt_reg, bit_cnt_next;
  // Bits still waiting to go out on mosi; the current bit already sits in mosi_reg.
  logic [DATA_WIDTH-2:0]   tx_sr_reg, tx_sr_next;
  logic [DATA_WIDTH-1:0]   rx_sr_reg, rx_sr_next;
  logic [DATA_WIDTH-1:0]   data_out_reg, data_out_next;
  logic                    sclk_reg, sclk_next;
  logic                    cs_reg, cs_next;
  logic                    mosi_reg, mosi_next;
  logic                    ready_reg, ready_next;
  logic                    busy_reg, busy_next;
  logic                    expired;

  // Current half-period has run its full SCLK_HALF cycles.
  assign expired = (hcnt_reg == HW'(SCLK_HALF - 1));

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      hcnt_reg     <= '0;
      bit_cnt_reg  <= '0;
      tx_sr_reg    <= '0;
      rx_sr_reg    <= '0;
      data_out_reg <= '0;
      sclk_reg     <= 1'b0;
      cs_reg       <= 1'b1;
      mosi_reg     <= 1'b0;
      ready_reg    <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      hcnt_reg     <= hcnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      tx_sr_reg    <= tx_sr_next;
      rx_sr_reg    <= rx_sr_next;
      data_out_reg <= data_out_next;
      sclk_reg     <= sclk_next;
      cs_reg       <= cs_next;
      mosi_reg     <= mosi_next;
      ready_reg    <= ready_next;
      busy_reg     <= busy_next;
    end
  end

  // Next-state logic: half-period timing, bit sequencing and frame hand-off.
  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg;
    tx_sr_next    = tx_sr_reg;
    rx_sr_next    = rx_sr_reg;
    data_out_next = data_out_reg;
    sclk_next     = sclk_reg;
    cs_next       = cs_reg;
    mosi_next     = mosi_reg;
    busy_next     = busy_reg;
    ready_next    = 1'b0;
    // Timed states count up to expiry then restart; IDLE keeps the counter parked.
    if (state_reg == ST_IDLE) begin
      hcnt_next = '0;
    end else if (expired) begin
      hcnt_next = '0;
    end else begin
      hcnt_next = hcnt_reg + HW'(1);
    end

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          tx_sr_next   = data_in[DATA_WIDTH-2:0];
          mosi_next    = data_in[DATA_WIDTH-1];
          cs_next      = 1'b0;
          bit_cnt_next = '0;
          busy_next    = 1'b1;
          state_next   = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (expired) begin
          sclk_next  = 1'b1;
          state_next = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (expired) begin
          sclk_next  = 1'b0;
          rx_sr_next = {rx_sr_reg[DATA_WIDTH-2:0], miso};
          if (bit_cnt_reg == CW'(DATA_WIDTH - 1)) begin
            state_next = ST_HOLD;
          end else begin
            mosi_next    = tx_sr_reg[DATA_WIDTH-2];
            tx_sr_next   = tx_sr_reg << 1;
            bit_cnt_next = bit_cnt_reg + CW'(1);
            state_next   = ST_LOW;
          end
        end
      end
      ST_LOW: begin
        if (expired) begin
          sclk_next  = 1'b1;
          state_next = ST_HIGH;
        end
      end
      ST_HOLD: begin
        if (expired) begin
          data_out_next = rx_sr_reg;
          ready_next    = 1'b1;
`ifdef SPI_MASTER_BURST_EN
          if (start) begin
            // Chain into the next frame: cs stays low, busy stays high.
            tx_sr_next   = data_in[DATA_WIDTH-2:0];
            mosi_next    = data_in[DATA_WIDTH-1];
            bit_cnt_next = '0;
            state_next   = ST_SETUP;
          end else begin
            cs_next    = 1'b1;
            mosi_next  = 1'b0;
            busy_next  = 1'b0;
            state_next = ST_IDLE;
          end
`else
          cs_next    = 1'b1;
          mosi_next  = 1'b0;
          busy_next  = 1'b0;
          state_next = ST_IDLE;
`endif
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign data_out = data_out_reg;
  assign ready    = ready_reg;
  assign busy     = busy_reg;
  assign mosi     = mosi_reg;
  assign sclk     = sclk_reg;
  assign cs       = cs_reg;

endmodule
